// File: rtl/matmul_scheduler_if.sv
// Loader and compute-unit handshake bundle for matmul_scheduler.
// master = scheduler side, slave = loader/compute-unit side.
interface matmul_scheduler_if #(
  parameter int MAX_SIZE_A = 32,
  parameter int MAX_SIZE_B = 32
);
  localparam int RA = $clog2(MAX_SIZE_A);
  localparam int CB = $clog2(MAX_SIZE_B);

  logic          valid_request;
  logic [RA-1:0] row_req;
  logic [CB-1:0] col_req;
  logic          val_rows;
  logic [RA-1:0] row_in;
  logic [CB-1:0] col_in;
  logic          mac_start;
  logic          mac_ready;
  logic          mac_done;

  modport master (
    output valid_request, row_req, col_req, mac_start,
    input  val_rows, row_in, col_in, mac_ready, mac_done
  );

  modport slave (
    input  valid_request, row_req, col_req, mac_start,
    output val_rows, row_in, col_in, mac_ready, mac_done
  );
endinterface

// File: rtl/matmul_scheduler.sv
// Walks every (A row, B column) pair, fetches operands from the loader with
// timeout/retry, and dispatches one compute-unit operation per pair.
module matmul_scheduler #(
  parameter int MAX_SIZE_A  = 32,
  parameter int MAX_SIZE_B  = 32,
  parameter int TIMEOUT     = 64,
  parameter int MAX_RETRIES = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        complete,
  input  logic [$clog2(MAX_SIZE_A):0] num_rows,
  input  logic [$clog2(MAX_SIZE_B):0] num_cols,
  matmul_scheduler_if.master          bus,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [15:0]                 elem_count
);
  localparam int RA  = $clog2(MAX_SIZE_A);
  localparam int CB  = $clog2(MAX_SIZE_B);
  localparam int TW  = $clog2(TIMEOUT);
  localparam int RTW = $clog2(MAX_RETRIES + 1);
  localparam logic [RA:0]    ROWS_MAX  = (RA+1)'(MAX_SIZE_A);
  localparam logic [CB:0]    COLS_MAX  = (CB+1)'(MAX_SIZE_B);
  localparam logic [TW-1:0]  TCNT_LAST = TW'(TIMEOUT - 1);
  localparam logic [RTW-1:0] RETRY_MAX = RTW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT_DATA, S_DISPATCH, S_WAIT_MAC, S_ADVANCE, S_DONE
  } state_t;

  state_t         state_reg, state_next;
  logic [RA-1:0]  row_reg, row_next, row_req_reg, row_req_next;
  logic [CB-1:0]  col_reg, col_next, col_req_reg, col_req_next;
  logic [RA:0]    nrows_reg, nrows_next, nrows_sat;
  logic [CB:0]    ncols_reg, ncols_next, ncols_sat;
  logic [RTW-1:0] retry_reg, retry_next;
  logic [TW-1:0]  tcnt_reg, tcnt_next;
  logic [15:0]    count_reg, count_next;
  logic           error_reg, error_next;
  logic           prev_complete_reg;
  logic           match, last_col, last_row;

  assign nrows_sat = (num_rows > ROWS_MAX) ? ROWS_MAX : num_rows;
  assign ncols_sat = (num_cols > COLS_MAX) ? COLS_MAX : num_cols;
  assign match     = bus.val_rows && (bus.row_in == row_req_reg) && (bus.col_in == col_req_reg);
  assign last_col  = ({1'b0, col_reg} == ncols_reg - (CB+1)'(1));
  assign last_row  = ({1'b0, row_reg} == nrows_reg - (RA+1)'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= S_IDLE;
      row_reg           <= '0;
      col_reg           <= '0;
      row_req_reg       <= '0;
      col_req_reg       <= '0;
      nrows_reg         <= '0;
      ncols_reg         <= '0;
      retry_reg         <= '0;
      tcnt_reg          <= '0;
      count_reg         <= '0;
      error_reg         <= 1'b0;
      prev_complete_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      row_reg           <= row_next;
      col_reg           <= col_next;
      row_req_reg       <= row_req_next;
      col_req_reg       <= col_req_next;
      nrows_reg         <= nrows_next;
      ncols_reg         <= ncols_next;
      retry_reg         <= retry_next;
      tcnt_reg          <= tcnt_next;
      count_reg         <= count_next;
      error_reg         <= error_next;
      prev_complete_reg <= complete;
    end
  end

  always_comb begin
    state_next   = state_reg;
    row_next     = row_reg;
    col_next     = col_reg;
    row_req_next = row_req_reg;
    col_req_next = col_req_reg;
    nrows_next   = nrows_reg;
    ncols_next   = ncols_reg;
    retry_next   = retry_reg;
    tcnt_next    = tcnt_reg;
    count_next   = count_reg;
    error_next   = error_reg;
    case (state_reg)
      S_IDLE: begin
        if (complete && !prev_complete_reg) begin
          nrows_next   = nrows_sat;
          ncols_next   = ncols_sat;
          error_next   = 1'b0;
          count_next   = '0;
          row_next     = '0;
          col_next     = '0;
          row_req_next = '0;
          col_req_next = '0;
          retry_next   = '0;
          state_next   = (nrows_sat == '0 || ncols_sat == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        tcnt_next  = '0;
        state_next = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        // A matching response beats a timeout landing in the same cycle.
        if (match) begin
          state_next = S_DISPATCH;
        end else if (tcnt_reg == TCNT_LAST) begin
          if (retry_reg < RETRY_MAX) begin
            retry_next = retry_reg + RTW'(1);
            state_next = S_REQ;
          end else begin
            error_next = 1'b1;
            state_next = S_DONE;
          end
        end else begin
          tcnt_next = tcnt_reg + TW'(1);
        end
      end
      S_DISPATCH: begin
        if (bus.mac_ready) state_next = S_WAIT_MAC;
      end
      S_WAIT_MAC: begin
        if (bus.mac_done) begin
          count_next = count_reg + 16'd1;
          state_next = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        retry_next = '0;
        if (last_col && last_row) begin
          state_next = S_DONE;
        end else if (last_col) begin
          col_next     = '0;
          row_next     = row_reg + RA'(1);
          col_req_next = '0;
          row_req_next = row_reg + RA'(1);
          state_next   = S_REQ;
        end else begin
          col_next     = col_reg + CB'(1);
          col_req_next = col_reg + CB'(1);
          state_next   = S_REQ;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign bus.valid_request = (state_reg == S_REQ);
  assign bus.row_req       = row_req_reg;
  assign bus.col_req       = col_req_reg;
  assign bus.mac_start     = (state_reg == S_DISPATCH) && bus.mac_ready;
  assign busy  = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign done  = (state_reg == S_DONE);
  assign error = error_reg;
  assign elem_count = count_reg;
endmodule

// File: tb/tb_matmul_scheduler.sv
// Randomized self-checking bench for matmul_scheduler: a reactive loader and
// compute-unit model drive the DUT, a pair-list reference model predicts results.
module tb_matmul_scheduler;
  localparam int MAX_SIZE_A  = 32;
  localparam int MAX_SIZE_B  = 32;
  localparam int TIMEOUT     = 64;
  localparam int MAX_RETRIES = 3;
  localparam int RA = $clog2(MAX_SIZE_A);
  localparam int CB = $clog2(MAX_SIZE_B);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          complete = 1'b0;
  logic [RA:0]   num_rows = '0;
  logic [CB:0]   num_cols = '0;
  logic          busy, done, error;
  logic [15:0]   elem_count;

  int n_checks = 0;
  int n_pass   = 0;

  int exp_req[$];
  int exp_elems;
  int exp_err;

  matmul_scheduler_if #(.MAX_SIZE_A(MAX_SIZE_A), .MAX_SIZE_B(MAX_SIZE_B)) bus ();

  matmul_scheduler #(
    .MAX_SIZE_A(MAX_SIZE_A), .MAX_SIZE_B(MAX_SIZE_B),
    .TIMEOUT(TIMEOUT), .MAX_RETRIES(MAX_RETRIES)
  ) dut (
    .clk(clk), .rst(rst), .complete(complete),
    .num_rows(num_rows), .num_cols(num_cols),
    .bus(bus),
    .busy(busy), .done(done), .error(error), .elem_count(elem_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Reference: row-major pair list; each request consumes one loader slot and
  // the first drop_n slots go unanswered. A pair gets 1+MAX_RETRIES attempts.
  task automatic build_model(input int rows, input int cols, input int drop_n);
    int idx = 0;
    int rs = (rows > MAX_SIZE_A) ? MAX_SIZE_A : rows;
    int cs = (cols > MAX_SIZE_B) ? MAX_SIZE_B : cols;
    exp_req.delete();
    exp_elems = 0;
    exp_err = 0;
    for (int r = 0; r < rs; r++) begin
      for (int c = 0; c < cs; c++) begin
        bit served = 0;
        for (int a = 0; a <= MAX_RETRIES && !served; a++) begin
          exp_req.push_back(r * 256 + c);
          if (idx >= drop_n) served = 1;
          idx++;
        end
        if (!served) begin
          exp_err = 1;
          return;
        end
        exp_elems++;
      end
    end
  endtask

  task automatic do_run(input string name, input int rows, input int cols, input int drop_n,
                        input int ldr_lat, input int mac_lat, input int ready_low,
                        input bit bogus, input bit via_reset, input int abort_at);
    int cyc = 0, n_req = 0, n_start = 0, first_req = -1;
    int last_req_cyc = -1, last_pair = -1, pair;
    int resp_cyc = -1, resp_pair = 0, bogus_cyc = -1, mac_cyc = -1;
    int ready_ok = 0, last_resp_cyc = -1, abort_cyc = -1, idle_hits = 0;
    bit finished = 0, aborted = 0;
    int got_req[$];
    build_model(rows, cols, drop_n);
    num_rows = (RA+1)'(rows);
    num_cols = (CB+1)'(cols);
    if (via_reset) rst = 1'b0;
    else complete = 1'b1;
    while (!finished && cyc < 20000) begin
      if (cyc == abort_cyc) begin
        rst = 1'b1;
        complete = 1'b0;
        #1;
        check_val({name, "_abort_outputs"},
                  {bus.valid_request, bus.mac_start, busy, done, error, elem_count}, 0);
        aborted = 1;
        break;
      end
      bus.val_rows = 1'b0;
      bus.mac_done = 1'b0;
      if (cyc == resp_cyc) begin
        bus.val_rows = 1'b1;
        bus.row_in = RA'(resp_pair / 256);
        bus.col_in = CB'(resp_pair % 256);
        last_resp_cyc = cyc;
        ready_ok = cyc + 1 + ready_low;
      end else if (cyc == bogus_cyc) begin
        bus.val_rows = 1'b1;
        bus.row_in = RA'(resp_pair / 256) ^ RA'(1);
        bus.col_in = CB'(resp_pair % 256);
      end
      bus.mac_ready = (cyc >= ready_ok);
      if (cyc == mac_cyc) bus.mac_done = 1'b1;
      #1;
      if (bus.valid_request) begin
        pair = int'(bus.row_req) * 256 + int'(bus.col_req);
        if (first_req < 0) first_req = cyc;
        if (pair == last_pair) check_val({name, "_retry_gap"}, cyc - last_req_cyc, TIMEOUT + 1);
        got_req.push_back(pair);
        if (n_req >= drop_n) begin
          resp_cyc = cyc + ldr_lat;
          resp_pair = pair;
          if (bogus) bogus_cyc = cyc + 1;
        end
        n_req++;
        last_pair = pair;
        last_req_cyc = cyc;
      end
      if (bus.mac_start) begin
        n_start++;
        check_val({name, "_mac_start_wait"}, cyc - last_resp_cyc, 1 + ready_low);
        mac_cyc = cyc + mac_lat;
        if (abort_at != 0 && n_start == abort_at) abort_cyc = cyc + 1;
      end
      if (done) begin
        finished = 1;
        if (exp_req.size() == 0) check_val({name, "_zero_done_cycle"}, cyc, 1);
        check_val({name, "_busy_at_done"}, busy, 0);
        check_val({name, "_error"}, error, exp_err);
        check_val({name, "_elem_count"}, elem_count, exp_elems);
      end
      @(negedge clk);
      cyc++;
    end
    bus.val_rows = 1'b0;
    bus.mac_done = 1'b0;
    if (aborted) return;
    if (!finished) check_val({name, "_done_within_budget"}, 0, 1);
    if (exp_req.size() > 0) check_val({name, "_first_req_latency"}, first_req, 1);
    check_val({name, "_req_count"}, got_req.size(), exp_req.size());
    for (int i = 0; i < got_req.size() && i < exp_req.size(); i++)
      check_val($sformatf("%s_req%0d", name, i), got_req[i], exp_req[i]);
    check_val({name, "_mac_starts"}, n_start, exp_elems);
    // complete stays high: no second run may start
    for (int i = 0; i < 8; i++) begin
      #1;
      idle_hits += int'(bus.valid_request) + int'(busy) + int'(done);
      @(negedge clk);
    end
    check_val({name, "_no_retrigger"}, idle_hits, 0);
    complete = 1'b0;
    @(negedge clk);
    $display("run %s rows=%0d cols=%0d drop=%0d: %0d requests, elem_count=%0d error=%0b",
             name, rows, cols, drop_n, got_req.size(), elem_count, error);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits;
    bus.val_rows = 1'b0;
    bus.row_in = '0;
    bus.col_in = '0;
    bus.mac_ready = 1'b0;
    bus.mac_done = 1'b0;
    rst = 1'b1;
    complete = 1'b1;
    num_rows = (RA+1)'(1);
    num_cols = (CB+1)'(1);
    repeat (3) @(negedge clk);
    #1;
    check_val("reset_outputs",
              {bus.valid_request, bus.mac_start, busy, done, error, elem_count,
               bus.row_req, bus.col_req}, 0);
    @(negedge clk);

    // complete already high when reset is released counts as a start edge
    do_run("rst_release", 1, 1, 0, 1, 2, 0, 0, 1, 0);
    do_run("run_2x3", 2, 3, 0, 1, 2, 0, 0, 0, 0);
    do_run("timeout_retry", 1, 1, 1, 1, 2, 0, 0, 0, 0);
    do_run("retry_exhaust", 1, 1, 100, 1, 2, 0, 0, 0, 0);
    do_run("error_clears", 1, 1, 0, 2, 1, 0, 0, 0, 0);
    do_run("tag_backpressure", 1, 2, 0, 3, 2, 5, 1, 0, 0);
    do_run("zero_cols", 3, 0, 0, 1, 1, 0, 0, 0, 0);
    do_run("saturate_rows", 40, 1, 0, 1, 1, 0, 0, 0, 0);

    // abort in WAIT_MAC of element 3, then late responses must be ignored
    do_run("mid_abort", 2, 3, 0, 1, 3, 0, 0, 0, 3);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.mac_done = 1'b1;
    bus.val_rows = 1'b1;
    bus.row_in = '0;
    bus.col_in = '0;
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      hits += int'(busy) + int'(bus.valid_request) + int'(bus.mac_start) + int'(elem_count != 0);
      @(negedge clk);
      bus.mac_done = 1'b0;
      bus.val_rows = 1'b0;
    end
    check_val("late_events_ignored", hits, 0);
    do_run("restart_after_abort", 2, 3, 0, 1, 2, 0, 0, 0, 0);

    for (int k = 0; k < 15; k++) begin
      int ll = $urandom_range(1, 5);
      do_run($sformatf("rand%0d", k), $urandom_range(1, 4), $urandom_range(1, 4),
             $urandom_range(0, 4), ll, $urandom_range(1, 4), $urandom_range(0, 3),
             (ll >= 2) && ($urandom_range(0, 1) == 1), 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
